// File: rtl/tomasula_types.sv
// Shared types for the out-of-order core: common data bus record and
// machine-wide sizing constants.
package tomasula_types;

   localparam int NUM_CDB_REQ = 4;
   localparam int ROB_DEPTH   = 8;
   localparam int CDB_TAG_W   = $clog2(ROB_DEPTH);
   localparam int CDB_DATA_W  = 32;

   // One broadcast on the common data bus
   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search. Starting at ptr and moving
// upward with wrap, the first asserted request wins; grant is at most one-hot.
module rr_picker #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   int            idx;
   logic [PW-1:0] idx_w;
   logic          found;

   // Walk N positions from ptr, folding the index back into range
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         idx_w = PW'(idx);
         if (!found && req[idx_w]) begin
            grant[idx_w] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one completed functional-unit result per cycle and
// broadcasts it on the common data bus one cycle later, with a one-hot
// valid-set decode for the ROB. A branch mispredict blocks new grants but
// lets an already registered broadcast go out.
// Optional: define CDB_ARB_BR_PRIO_EN to give requester 0 (branch unit)
// absolute priority; such grants leave the round-robin pointer untouched.
module cdb_arbiter #(
   parameter  int NUM_REQ   = tomasula_types::NUM_CDB_REQ,
   parameter  int ROB_DEPTH = tomasula_types::ROB_DEPTH,
   parameter  int DATA_W    = tomasula_types::CDB_DATA_W,
   localparam int TAG_W     = $clog2(ROB_DEPTH),
   localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]              gnt,
   input  logic                            branch_mispredict,
   output logic                            cdb_valid,
   output logic [TAG_W-1:0]                cdb_tag,
   output logic [DATA_W-1:0]               cdb_data,
   output logic                            set_rob_valid [ROB_DEPTH]
);

   import tomasula_types::*;

   // The bus record uses the package widths; the parameters are expected
   // to match the machine-wide constants.
   logic [PW-1:0]      ptr_q, ptr_d;
   cdb_t               bcast_q, bcast_d;
   logic [NUM_REQ-1:0] rr_gnt, gnt_raw;
   logic               prio_win;
   logic [PW-1:0]      win_idx;
   logic               any_gnt;

   rr_picker #(.N(NUM_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (rr_gnt)
   );

   // Final grant: optional branch override, then squash on flush or reset
   always_comb begin
      prio_win = 1'b0;
      gnt_raw  = rr_gnt;
`ifdef CDB_ARB_BR_PRIO_EN
      if (req[0]) begin
         prio_win = 1'b1;
         gnt_raw  = NUM_REQ'(1);
      end
`endif
      gnt = (rst || branch_mispredict) ? '0 : gnt_raw;
   end

   // Encode the one-hot grant into an index for muxing and pointer update
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i]) win_idx = PW'(i);
   end

   assign any_gnt = |gnt;

   // Next broadcast and pointer; tag/data hold when nothing is granted
   always_comb begin
      ptr_d         = ptr_q;
      bcast_d       = bcast_q;
      bcast_d.valid = any_gnt;
      if (any_gnt) begin
         bcast_d.tag  = req_tag[win_idx];
         bcast_d.data = req_data[win_idx];
         if (!prio_win)
            ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
      end
   end

   // State registers; reset also drops a grant made in the reset cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         bcast_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         bcast_q <= bcast_d;
      end
   end

   assign cdb_valid = bcast_q.valid;
   assign cdb_tag   = bcast_q.tag;
   assign cdb_data  = bcast_q.data;

   // ROB valid-set decode straight off the registered broadcast
   always_comb begin
      for (int k = 0; k < ROB_DEPTH; k++)
         set_rob_valid[k] = bcast_q.valid && (bcast_q.tag == TAG_W'(k));
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run, all
// compared against a behavioural round-robin model kept here.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int D  = 8;
   localparam int DW = 32;

   logic                   clk = 1'b0;
   logic                   rst, bm;
   logic [N-1:0]           req, gnt;
   logic [N-1:0][2:0]      tags;
   logic [N-1:0][DW-1:0]   datas;
   logic                   cdb_valid;
   logic [2:0]             cdb_tag;
   logic [DW-1:0]          cdb_data;
   logic                   srv [D];

   int checks = 0;
   int errors = 0;

   // model state
   int          m_ptr;
   bit          m_valid;
   int          m_tag;
   logic [31:0] m_data;

   // per-cycle observations and model expectations
   logic [N-1:0]  obs_gnt, exp_gnt;
   logic          obs_valid, exp_valid;
   logic [2:0]    obs_tag, exp_tag;
   logic [DW-1:0] obs_data, exp_data;
   logic [D-1:0]  obs_srv, exp_srv;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req),
      .req_tag           (tags),
      .req_data          (datas),
      .gnt               (gnt),
      .branch_mispredict (bm),
      .cdb_valid         (cdb_valid),
      .cdb_tag           (cdb_tag),
      .cdb_data          (cdb_data),
      .set_rob_valid     (srv)
   );

   // expected grant from the arbitration rules
   function automatic logic [N-1:0] model_gnt();
      if (rst || bm) return '0;
`ifdef CDB_ARB_BR_PRIO_EN
      if (req[0]) return N'(1);
`endif
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_ptr + i) % N;
         if (req[k]) return N'(1) << k;
      end
      return '0;
   endfunction

   // drive one cycle, sample mid-cycle, then advance the model at the edge
   task automatic run_cycle(input logic [N-1:0] r, input logic b, input logic rs);
      int w;
      req = r; bm = b; rst = rs;
      @(negedge clk);
      obs_gnt = gnt; obs_valid = cdb_valid; obs_tag = cdb_tag; obs_data = cdb_data;
      for (int k = 0; k < D; k++) begin
         obs_srv[k] = srv[k];
         exp_srv[k] = m_valid && (m_tag == k);
      end
      exp_gnt = model_gnt(); exp_valid = m_valid; exp_tag = 3'(m_tag); exp_data = m_data;
      @(posedge clk);
      if (rs) begin
         m_ptr = 0; m_valid = 0; m_tag = 0; m_data = '0;
      end else if (exp_gnt != '0) begin
         w = 0;
         for (int i = 0; i < N; i++) if (exp_gnt[i]) w = i;
         m_valid = 1; m_tag = int'(tags[w]); m_data = datas[w];
`ifdef CDB_ARB_BR_PRIO_EN
         if (w != 0) m_ptr = (w + 1) % N;
`else
         m_ptr = (w + 1) % N;
`endif
      end else begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      run_cycle(4'b1111, 1'b0, 1'b1);
      run_cycle(4'b1111, 1'b0, 1'b1);
      checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", obs_gnt); end
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", obs_valid); end
      checks++; if (obs_tag !== 3'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", obs_tag); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", obs_data); end
      checks++; if (obs_srv !== 8'd0) begin errors++; $display("FAIL reset_srv got %b exp 0", obs_srv); end
   endtask

   task automatic test_basic();
      run_cycle('0, 1'b0, 1'b1);
      tags[1] = 3'd3; datas[1] = 32'hAA;
      tags[2] = 3'd5; datas[2] = 32'hBB;
      run_cycle(4'b0110, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL basic_c0_gnt got %b exp 0010", obs_gnt); end
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_c0_valid got %b exp 0", obs_valid); end
      run_cycle(4'b0100, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL basic_c1_gnt got %b exp 0100", obs_gnt); end
      checks++; if (obs_valid !== 1'b1 || obs_tag !== 3'd3 || obs_data !== 32'hAA)
         begin errors++; $display("FAIL basic_c1_cdb got v%b t%0d d%h exp v1 t3 dAA", obs_valid, obs_tag, obs_data); end
      checks++; if (obs_srv !== 8'b0000_1000) begin errors++; $display("FAIL basic_c1_srv got %b exp 00001000", obs_srv); end
      run_cycle(4'b0000, 1'b0, 1'b0);
      checks++; if (obs_valid !== 1'b1 || obs_tag !== 3'd5 || obs_data !== 32'hBB)
         begin errors++; $display("FAIL basic_c2_cdb got v%b t%0d d%h exp v1 t5 dBB", obs_valid, obs_tag, obs_data); end
      checks++; if (obs_srv !== 8'b0010_0000) begin errors++; $display("FAIL basic_c2_srv got %b exp 00100000", obs_srv); end
      run_cycle(4'b0000, 1'b0, 1'b0);
      checks++; if (obs_valid !== 1'b0 || obs_tag !== 3'd5 || obs_data !== 32'hBB)
         begin errors++; $display("FAIL basic_hold got v%b t%0d d%h exp v0 t5 dBB", obs_valid, obs_tag, obs_data); end
      checks++; if (obs_srv !== 8'd0) begin errors++; $display("FAIL basic_hold_srv got %b exp 0", obs_srv); end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] eg;
      run_cycle('0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) begin tags[i] = 3'(i + 1); datas[i] = 32'h100 + 32'(i); end
      for (int c = 0; c < 9; c++) begin
         run_cycle(c < 8 ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
`ifdef CDB_ARB_BR_PRIO_EN
         eg = (c < 8) ? 4'b0001 : 4'b0000;
`else
         eg = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
`endif
         checks++; if (obs_gnt !== eg) begin errors++; $display("FAIL b2b_gnt c%0d got %b exp %b", c, obs_gnt, eg); end
         if (c >= 1) begin
            checks++; if (obs_valid !== 1'b1 || obs_tag !== exp_tag)
               begin errors++; $display("FAIL b2b_cdb c%0d got v%b t%0d exp v1 t%0d", c, obs_valid, obs_tag, exp_tag); end
         end
      end
   endtask

   task automatic test_wrap();
      run_cycle('0, 1'b0, 1'b1);
      run_cycle(4'b0100, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL wrap_g2 got %b exp 0100", obs_gnt); end
      run_cycle(4'b1000, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got %b exp 1000", obs_gnt); end
      run_cycle(4'b1001, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL wrap_g0 got %b exp 0001", obs_gnt); end
      run_cycle(4'b1101, 1'b0, 1'b0);
`ifdef CDB_ARB_BR_PRIO_EN
      checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL wrap_ptr got %b exp 0001", obs_gnt); end
`else
      checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL wrap_ptr got %b exp 0100", obs_gnt); end
`endif
   endtask

   task automatic test_flush();
      run_cycle('0, 1'b0, 1'b1);
      tags[1] = 3'd6; datas[1] = 32'h1234;
      run_cycle(4'b0010, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL flush_pre got %b exp 0010", obs_gnt); end
      run_cycle(4'b0010, 1'b1, 1'b0);
      checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL flush_gnt got %b exp 0000", obs_gnt); end
      checks++; if (obs_valid !== 1'b1 || obs_tag !== 3'd6 || obs_data !== 32'h1234)
         begin errors++; $display("FAIL flush_inflight got v%b t%0d d%h exp v1 t6 d1234", obs_valid, obs_tag, obs_data); end
      run_cycle(4'b0000, 1'b0, 1'b0);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %b exp 0", obs_valid); end
      run_cycle(4'b1111, 1'b0, 1'b0);
`ifdef CDB_ARB_BR_PRIO_EN
      checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL flush_ptr got %b exp 0001", obs_gnt); end
`else
      checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL flush_ptr got %b exp 0100", obs_gnt); end
`endif
   endtask

   task automatic test_br_prio();
      logic [N-1:0] eg;
      run_cycle('0, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         run_cycle(4'b0011, 1'b0, 1'b0);
`ifdef CDB_ARB_BR_PRIO_EN
         eg = 4'b0001;
`else
         eg = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
         checks++; if (obs_gnt !== eg) begin errors++; $display("FAIL prio_gnt c%0d got %b exp %b", c, obs_gnt, eg); end
      end
      run_cycle(4'b1110, 1'b0, 1'b0);
`ifdef CDB_ARB_BR_PRIO_EN
      eg = 4'b0010;
`else
      eg = 4'b0100;
`endif
      checks++; if (obs_gnt !== eg) begin errors++; $display("FAIL prio_ptr got %b exp %b", obs_gnt, eg); end
   endtask

   task automatic test_rst_midstream();
      run_cycle('0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) run_cycle(4'b1111, 1'b0, 1'b0);
      run_cycle(4'b1111, 1'b0, 1'b1);
      checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b exp 0000", obs_gnt); end
      run_cycle(4'b1111, 1'b0, 1'b0);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", obs_valid); end
      checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first got %b exp 0001", obs_gnt); end
   endtask

   task automatic test_random();
      logic [N-1:0] cur;
      logic         b, rs;
      run_cycle('0, 1'b0, 1'b1);
      cur = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!cur[i] || obs_gnt[i]) begin
               cur[i]   = 1'($urandom_range(0, 1));
               tags[i]  = 3'($urandom);
               datas[i] = $urandom;
            end
         end
         b  = ($urandom_range(0, 9) == 0);
         rs = ($urandom_range(0, 39) == 0);
         run_cycle(cur, b, rs);
         checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, obs_gnt, exp_gnt); end
         checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, obs_valid, exp_valid); end
         checks++; if (obs_tag !== exp_tag) begin errors++; $display("FAIL rnd_tag c%0d got %0d exp %0d", c, obs_tag, exp_tag); end
         checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", c, obs_data, exp_data); end
         checks++; if (obs_srv !== exp_srv) begin errors++; $display("FAIL rnd_srv c%0d got %b exp %b", c, obs_srv, exp_srv); end
      end
   endtask

   initial begin
      rst = 1'b1; bm = 1'b0; req = '0; tags = '0; datas = '0;
      m_ptr = 0; m_valid = 0; m_tag = 0; m_data = '0;
      obs_gnt = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_flush();
      test_br_prio();
      test_rst_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached before summary");
      $fatal(1);
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of functional-unit requesters; requester 0 is the branch unit.
REQ-002 The block SHALL have parameter ROB_DEPTH, default 8, giving the ROB entries; the tag width is log2(ROB_DEPTH) = 3.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the result width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: requester i holds a completed result.
REQ-007 The block SHALL have port req_tag, input, NUM_REQ x 3 bits: the ROB index of each requester's result.
REQ-008 The block SHALL have port req_data, input, NUM_REQ x DATA_W bits: each requester's result value.
REQ-009 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant, combinational in the same cycle as req.
REQ-010 The block SHALL have port branch_mispredict, input, 1 bit: the flush request.
REQ-011 The block SHALL have port cdb_valid, output, 1 bit: the broadcast is valid this cycle.
REQ-012 The block SHALL have port cdb_tag, output, 3 bits: the broadcast ROB index.
REQ-013 The block SHALL have port cdb_data, output, DATA_W bits: the broadcast value.
REQ-014 The block SHALL have port set_rob_valid, output, unpacked array of ROB_DEPTH x 1 bit: one-hot decode of cdb_tag, qualified by cdb_valid, driving the ROB valid-set inputs.

Function
REQ-015 Handshake SHALL be: a requester holds req, tag and data stable until it sees gnt[i]=1 in the same cycle, then drops or changes them on the next cycle.
REQ-016 gnt SHALL be at most one-hot, and gnt[i]=1 only if req[i]=1.
REQ-017 Arbitration SHALL be round-robin: search upward from priority pointer ptr (mod NUM_REQ); the first requester found wins.
REQ-018 On a grant to i, ptr SHALL update to (i+1) mod NUM_REQ at the next edge; with no grant, ptr SHALL hold.
REQ-019 The winner's tag and data SHALL be registered; cdb_valid/cdb_tag/cdb_data SHALL appear exactly 1 cycle after the grant, and cdb_valid SHALL be high for exactly 1 cycle per grant.
REQ-020 With no grant in a cycle, cdb_valid SHALL be 0 in the next cycle, and cdb_tag/cdb_data SHALL hold their last values.
REQ-021 set_rob_valid[k] SHALL equal cdb_valid AND (cdb_tag==k), purely combinational from the registered outputs.
REQ-022 While branch_mispredict=1, gnt SHALL be all-zero, ptr SHALL hold, and cdb_valid SHALL be 0 in the next cycle.
REQ-023 A broadcast already registered when branch_mispredict rises SHALL still be presented; the flush does not suppress an in-flight broadcast.
REQ-024 Back-to-back grants to different requesters on consecutive cycles SHALL be supported, giving a throughput of 1 broadcast per cycle.
REQ-025 Pointer wrap-around SHALL apply: a grant to NUM_REQ-1 sets ptr=0.
REQ-026 Duplicate tags across requesters SHALL NOT be checked; the block broadcasts them as granted.

Reset
REQ-027 While rst=1: ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, gnt all-zero, and set_rob_valid all-zero.
REQ-028 A grant issued in the same cycle as rst assertion SHALL be discarded; no broadcast follows it.

Configuration
REQ-029 With CDB_ARB_BR_PRIO_EN defined, requester 0 SHALL win whenever req[0]=1, regardless of ptr; such a grant SHALL NOT update ptr.
REQ-030 Without CDB_ARB_BR_PRIO_EN, requester 0 SHALL take part in plain round-robin like every other requester.

Structure
REQ-031 A cdb_t struct {valid, tag, data} and the constants NUM_CDB_REQ and ROB_DEPTH SHALL live in the shared tomasula_types package.
REQ-032 The round-robin search SHALL be a separate combinational sub-module rr_picker (inputs req and ptr; output one-hot grant); cdb_arbiter holds all state.

Verification
REQ-033 Scenario: reset, then req=4'b0110 with tag1=3, data1=0xAA, tag2=5, data2=0xBB -> cycle 0 gnt=0010, cycle 1 gnt=0100 with cdb_tag=3 and set_rob_valid[3]=1, cycle 2 cdb_tag=5 and cdb_data=0xBB.
REQ-034 Scenario: req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with cdb_valid high for 8 consecutive cycles.
REQ-035 Scenario: req=4'b1000 with ptr=3, then req=4'b1001 -> grant 3, then grant 0 (wrap), ptr=1.
REQ-036 Scenario: a grant in cycle N and branch_mispredict=1 in cycle N+1 with req=4'b0010 -> broadcast in N+1 still occurs; gnt=0 and no broadcast in N+2.
REQ-037 Scenario: with CDB_ARB_BR_PRIO_EN defined, req=4'b0011 held -> grant 0 every cycle, requester 1 starved, ptr unchanged; without the macro the grants alternate 0,1.
REQ-038 Scenario: rst asserted mid-stream while req=4'b1111 -> next cycle cdb_valid=0; first grant after release goes to requester 0.
